w_grf: RTL and testbench
========================

# w_grf

Write-back stage and general register file of the pipelined MIPS core. It sits directly downstream of the M/W pipeline register. It selects the write-back value from the W-stage fields (ALU result, load data, PC+8, CP0 read), commits it to the 32×32 GRF on the clock edge, serves the two D-stage read ports, and emits a registered retirement trace plus a retired-instruction counter for the test bench and debug.

## Interface
Parameters:
- `RESET_PC`, `32'h0000_3000`: PC value that is never a bubble marker; used only for trace sanity. The bubble marker is `W_PC == 0`.

Ports:
- `clk` input 1: clock; all state updates on posedge.
- `reset` input 1: synchronous, active-high; clears GRF, trace and counter.
- `W_regWE` input 1: instruction in W writes the GRF.
- `W_wdSel` input 2: write-data select. 0 = `W_aluResult`, 1 = `W_dataOUT`, 2 = `W_PC8`, 3 = `W_CP0_OUT`.
- `W_writeReg_NUM` input 5: destination register.
- `W_PC` input 32: PC of the W-stage instruction; 0 marks a bubble or flush.
- `W_aluResult`, `W_dataOUT`, `W_PC8`, `W_CP0_OUT` input 32 each: candidate write data.
- `D_rs_NUM`, `D_rt_NUM` input 5 each: read addresses.
- `D_rs_DATA`, `D_rt_DATA` output 32 each: read data (combinational).
- `W_writeData` output 32: selected write-back value (combinational, for forwarding to E/M).
- `trace_valid` output 1: registered; a GRF write committed last cycle.
- `trace_pc`, `trace_data` output 32 each; `trace_reg` output 5: registered details of that write.
- `retired_cnt` output 32: count of non-bubble instructions that left W.

## Operation
- Write data: `W_writeData` is the 4:1 mux on `W_wdSel`. It is always driven, whatever `W_regWE` is.
- Write active: `wr = W_regWE && W_writeReg_NUM != 0`. On posedge with `wr`, `GRF[W_writeReg_NUM] <= W_writeData`.
- $0: never written. Reads of $0 always return 0.
- Reads: `D_rs_DATA = (rs == 0) ? 0 : GRF[rs]`, with the bypass below applied when configured. `D_rt_DATA` works the same way.
- Trace: each posedge sets `trace_valid <= wr`. When `wr`, `trace_pc <= W_PC`, `trace_reg <= W_writeReg_NUM` and `trace_data <= W_writeData`. Otherwise these three hold their previous values.
- Counter: each posedge with `W_PC != 0` increments `retired_cnt`. It wraps modulo 2^32. The count includes non-writing instructions (stores, branches).
- Flushed W stage: all fields are 0, so `wr = 0` and there is no count. This needs no extra handling.

## Timing
- Reset (synchronous): all 32 GRF entries, `trace_valid`, `trace_pc`, `trace_data`, `trace_reg` and `retired_cnt` become 0 on the reset edge.
- `reset` has priority over a simultaneous write. The write is dropped and no trace or count is produced.
- Reset asserted mid-stream: the state is 0 on the cycle after the reset edge. The first post-reset write traces one cycle after its commit edge.
- Write latency: the value is visible in the array from the edge after `wr` is sampled.
- Read ports: zero-latency combinational.
- Trace latency: exactly 1 cycle after the commit edge.
- Counter: reflects instructions sampled on previous edges. It has no combinational path from `W_PC`.
- Simultaneous write and read of the same register:
  - Without bypass, the read returns the old value.
  - With bypass, the read returns `W_writeData` (see Configuration).
- `rs == rt == write register`: both ports behave identically.

## Configuration
- `W_GRF_BYPASS_EN` defined: the internal write-to-read bypass is compiled in.
  - If `wr` and `D_rs_NUM == W_writeReg_NUM`, then `D_rs_DATA = W_writeData` in the same cycle. The same rule applies to rt.
  - $0 still reads 0.
  - The D-stage forwarding unit then needs no W→D path.
- Not defined: reads return only the stored array contents. The D-stage forwarding unit must supply W→D forwarding itself.

## Test plan
- Reset and readback: assert `reset` 1 cycle, then read rs = 5, rt = 31 -> both 0; `retired_cnt = 0`; `trace_valid = 0`.
- Write through each select: `W_regWE = 1`, reg 8, `W_PC = 0x3000`, `aluResult = 0x1234`, sel 0 -> next cycle `D_rs_DATA(8) = 0x1234`, `trace_valid = 1`, `trace_pc = 0x3000`, `trace_reg = 8`, `trace_data = 0x1234`. Repeat with sel 1/2/3 using `0xDEAD0000` / `0x3008` / `0x0000_0010`.
- $0 protection: write `0xFFFF_FFFF` to reg 0 with WE = 1 -> reads of $0 are 0; `trace_valid = 0`; `retired_cnt` still increments.
- Same-cycle bypass: reg 9 holds 7; write 42 to reg 9 while rs = 9.
  - Macro on: `D_rs_DATA = 42` in the same cycle.
  - Macro off: `D_rs_DATA = 7`, then 42 the next cycle.
- Bubbles and counter: drive 3 instructions with PCs 0x3000, 0x3004, 0x3008, a bubble (all zero), then 0x300C -> `retired_cnt = 4`; no trace on the bubble cycle.
- Reset priority and wrap: force `retired_cnt` to `0xFFFF_FFFF` via 2^32−1 non-bubbles (or a bench backdoor); one more non-bubble -> 0. Then assert `reset` together with a write of 5 to reg 3 -> reg 3 reads 0 and `trace_valid = 0`.

Source files
------------

// File: rtl/w_grf.sv
// w_grf: MIPS write-back stage and 32x32 general register file.
// Selects the write-back value, commits it to the GRF, serves two
// combinational read ports and emits a registered retirement trace
// plus a retired-instruction counter.
// Optional feature macro: W_GRF_BYPASS_EN (same-cycle write-to-read bypass).
module w_grf #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        W_regWE,
    input  logic [1:0]  W_wdSel,
    input  logic [4:0]  W_writeReg_NUM,
    input  logic [31:0] W_PC,
    input  logic [31:0] W_aluResult,
    input  logic [31:0] W_dataOUT,
    input  logic [31:0] W_PC8,
    input  logic [31:0] W_CP0_OUT,
    input  logic [4:0]  D_rs_NUM,
    input  logic [4:0]  D_rt_NUM,
    output logic [31:0] D_rs_DATA,
    output logic [31:0] D_rt_DATA,
    output logic [31:0] W_writeData,
    output logic        trace_valid,
    output logic [31:0] trace_pc,
    output logic [31:0] trace_data,
    output logic [4:0]  trace_reg,
    output logic [31:0] retired_cnt
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned RW   = 5;

    logic [XLEN-1:0] grf [NREG];
    logic [XLEN-1:0] cnt_q;
    logic            wr;

    // Write-back data select; driven regardless of the write enable
    always_comb begin
        W_writeData = W_aluResult;
        case (W_wdSel)
            2'd0:    W_writeData = W_aluResult;
            2'd1:    W_writeData = W_dataOUT;
            2'd2:    W_writeData = W_PC8;
            2'd3:    W_writeData = W_CP0_OUT;
            default: W_writeData = W_aluResult;
        endcase
    end

    // $0 is hard-wired, so a write to it is not a write at all
    assign wr = W_regWE && (W_writeReg_NUM != RW'(0));

    // Register array: synchronous clear, reset wins over a same-edge write
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                grf[i] <= '0;
            end
        end else if (wr) begin
            grf[W_writeReg_NUM] <= W_writeData;
        end
    end

    // Read ports; wr already excludes $0, so the bypass can never expose it
    always_comb begin
        D_rs_DATA = (D_rs_NUM == RW'(0)) ? XLEN'(0) : grf[D_rs_NUM];
        D_rt_DATA = (D_rt_NUM == RW'(0)) ? XLEN'(0) : grf[D_rt_NUM];
`ifdef W_GRF_BYPASS_EN
        if (wr && (D_rs_NUM == W_writeReg_NUM)) begin
            D_rs_DATA = W_writeData;
        end
        if (wr && (D_rt_NUM == W_writeReg_NUM)) begin
            D_rt_DATA = W_writeData;
        end
`endif
    end

    // Retirement trace: pulse on commit, details held until the next write
    always_ff @(posedge clk) begin
        if (reset) begin
            trace_valid <= 1'b0;
            trace_pc    <= '0;
            trace_data  <= '0;
            trace_reg   <= '0;
        end else begin
            trace_valid <= wr;
            if (wr) begin
                // A committing instruction can never sit below the reset vector
                assert (W_PC >= RESET_PC);
                trace_pc   <= W_PC;
                trace_data <= W_writeData;
                trace_reg  <= W_writeReg_NUM;
            end
        end
    end

    // Retired-instruction counter; PC of zero marks a bubble or flush
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (W_PC != XLEN'(0)) begin
            cnt_q <= cnt_q + XLEN'(1);
        end
    end

    assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_w_grf.sv
// tb_w_grf: self-checking bench for w_grf (table vectors + trace scoreboard).
module tb_w_grf;

`ifdef W_GRF_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        W_regWE;
    logic [1:0]  W_wdSel;
    logic [4:0]  W_writeReg_NUM;
    logic [31:0] W_PC, W_aluResult, W_dataOUT, W_PC8, W_CP0_OUT;
    logic [4:0]  D_rs_NUM, D_rt_NUM;
    logic [31:0] D_rs_DATA, D_rt_DATA, W_writeData;
    logic        trace_valid;
    logic [31:0] trace_pc, trace_data;
    logic [4:0]  trace_reg;
    logic [31:0] retired_cnt;

    always #5 clk = ~clk;

    w_grf dut (
        .clk(clk), .reset(reset), .W_regWE(W_regWE), .W_wdSel(W_wdSel),
        .W_writeReg_NUM(W_writeReg_NUM), .W_PC(W_PC), .W_aluResult(W_aluResult),
        .W_dataOUT(W_dataOUT), .W_PC8(W_PC8), .W_CP0_OUT(W_CP0_OUT),
        .D_rs_NUM(D_rs_NUM), .D_rt_NUM(D_rt_NUM), .D_rs_DATA(D_rs_DATA),
        .D_rt_DATA(D_rt_DATA), .W_writeData(W_writeData), .trace_valid(trace_valid),
        .trace_pc(trace_pc), .trace_data(trace_data), .trace_reg(trace_reg),
        .retired_cnt(retired_cnt)
    );

    typedef struct {
        logic        rst;
        logic        we;
        logic [1:0]  sel;
        logic [4:0]  wreg;
        logic [31:0] pc, alu, dout, pc8, cp0;
        logic [4:0]  rs, rt;
        logic [31:0] exp_wd;
        logic        hard;
        logic [31:0] hard_rs;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rg;
        logic [31:0] data;
    } tr_t;

    tr_t         sb[$];
    vec_t        tbl[$];
    logic [31:0] m_grf [32];
    logic [31:0] m_cnt;
    tr_t         m_last;
    int          checks = 0;
    int          fails  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic we, input logic [1:0] sel,
                                input logic [4:0] wreg, input logic [31:0] pc,
                                input logic [31:0] alu, input logic [31:0] dout,
                                input logic [31:0] pc8, input logic [31:0] cp0,
                                input logic [4:0] rs, input logic [4:0] rt,
                                input logic [31:0] exp_wd, input logic hard,
                                input logic [31:0] hard_rs);
        vec_t v;
        v.rst = rst; v.we = we; v.sel = sel; v.wreg = wreg; v.pc = pc;
        v.alu = alu; v.dout = dout; v.pc8 = pc8; v.cp0 = cp0;
        v.rs = rs; v.rt = rt; v.exp_wd = exp_wd; v.hard = hard; v.hard_rs = hard_rs;
        return v;
    endfunction

    function automatic logic [31:0] wd_of(input vec_t v);
        case (v.sel)
            2'd0:    return v.alu;
            2'd1:    return v.dout;
            2'd2:    return v.pc8;
            default: return v.cp0;
        endcase
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] r, input logic byp,
                                             input logic [31:0] wd);
        if (r == 5'd0) return 32'h0;
        if (byp && BYPASS) return wd;
        return m_grf[r];
    endfunction

    // One clock: drive, check combinational outputs, update model, check registered outputs
    task automatic cycle(input vec_t v);
        logic        wr;
        logic [31:0] wd;
        tr_t         t;
        reset = v.rst; W_regWE = v.we; W_wdSel = v.sel; W_writeReg_NUM = v.wreg;
        W_PC = v.pc; W_aluResult = v.alu; W_dataOUT = v.dout; W_PC8 = v.pc8;
        W_CP0_OUT = v.cp0; D_rs_NUM = v.rs; D_rt_NUM = v.rt;
        #2;
        wd = wd_of(v);
        wr = v.we && (v.wreg != 5'd0);
        chk("write_data", W_writeData, v.exp_wd);
        if (!v.rst) begin
            chk("rs_data", D_rs_DATA, exp_read(v.rs, wr && v.rs == v.wreg, wd));
            chk("rt_data", D_rt_DATA, exp_read(v.rt, wr && v.rt == v.wreg, wd));
        end
        if (v.hard) chk("rs_fixed", D_rs_DATA, v.hard_rs);
        if (v.rst) begin
            for (int i = 0; i < 32; i++) m_grf[i] = 32'h0;
            sb.delete();
            m_cnt  = 32'h0;
            m_last = '{32'h0, 5'd0, 32'h0};
        end else begin
            if (wr) begin
                t.pc = v.pc; t.rg = v.wreg; t.data = wd;
                sb.push_back(t);
                m_grf[v.wreg] = wd;
            end
            if (v.pc != 32'h0) m_cnt = m_cnt + 32'd1;
        end
        @(posedge clk);
        #1;
        chk("retired_cnt", retired_cnt, m_cnt);
        if (sb.size() > 0) begin
            t = sb.pop_front();
            chk("trace_valid", 32'(trace_valid), 32'd1);
            chk("trace_pc", trace_pc, t.pc);
            chk("trace_reg", 32'(trace_reg), 32'(t.rg));
            chk("trace_data", trace_data, t.data);
            m_last = t;
        end else begin
            chk("trace_valid", 32'(trace_valid), 32'd0);
            chk("trace_pc_hold", trace_pc, m_last.pc);
            chk("trace_reg_hold", 32'(trace_reg), 32'(m_last.rg));
            chk("trace_data_hold", trace_data, m_last.data);
        end
    endtask

    initial begin
        vec_t        v;
        logic [31:0] byp9;
        for (int i = 0; i < 32; i++) m_grf[i] = 32'h0;
        m_cnt  = 32'h0;
        m_last = '{32'h0, 5'd0, 32'h0};
        byp9   = BYPASS ? 32'd42 : 32'd7;

        // Reset, readback, each write-data select, $0 protection, same-cycle read
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 31, 0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 8, 32'h3000, 32'h1234, 32'hDEAD0000, 32'h3008, 32'h10, 8, 0, 32'h1234, 0, 0));
        tbl.push_back(mk(0, 1, 1, 8, 32'h3004, 32'h1234, 32'hDEAD0000, 32'h3008, 32'h10, 8, 8, 32'hDEAD0000, 0, 0));
        tbl.push_back(mk(0, 1, 2, 8, 32'h3008, 32'h1234, 32'hDEAD0000, 32'h3008, 32'h10, 8, 0, 32'h3008, 0, 0));
        tbl.push_back(mk(0, 1, 3, 8, 32'h300C, 32'h1234, 32'hDEAD0000, 32'h3008, 32'h10, 8, 0, 32'h10, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 8, 8, 0, 1, 32'h10));
        tbl.push_back(mk(0, 1, 0, 0, 32'h3010, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 32'hFFFFFFFF, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 9, 32'h3014, 32'd7, 0, 0, 0, 1, 2, 32'd7, 0, 0));
        tbl.push_back(mk(0, 1, 0, 9, 32'h3018, 32'd42, 0, 0, 0, 9, 9, 32'd42, 1, byp9));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 9, 0, 1, 32'd42));
        foreach (tbl[i]) cycle(tbl[i]);
        chk("cnt_after_table", retired_cnt, 32'd7);

        // Bubbles and counter
        cycle(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        cycle(mk(0, 1, 0, 1, 32'h3000, 32'h11, 0, 0, 0, 1, 2, 32'h11, 0, 0));
        cycle(mk(0, 1, 1, 2, 32'h3004, 0, 32'h22, 0, 0, 1, 2, 32'h22, 0, 0));
        cycle(mk(0, 1, 2, 3, 32'h3008, 0, 0, 32'h3010, 0, 3, 2, 32'h3010, 0, 0));
        cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 1, 32'h11));
        chk("bubble_no_trace", 32'(trace_valid), 32'd0);
        cycle(mk(0, 0, 0, 5, 32'h300C, 32'h99, 0, 0, 0, 3, 1, 32'h99, 1, 32'h3010));
        chk("cnt_four", retired_cnt, 32'd4);

        // Random traffic against the model; bubbles carry all-zero fields
        for (int n = 0; n < 60; n++) begin
            v = mk(0, 1'($urandom_range(0, 1)), 2'($urandom), 5'($urandom),
                   32'h3000 + 32'($urandom_range(0, 255)) * 32'd4,
                   $urandom, $urandom, $urandom, $urandom,
                   5'($urandom), 5'($urandom), 0, 0, 0);
            if (n % 3 == 0) v.rs = v.wreg;
            if (n % 5 == 0) v.rt = v.wreg;
            if ($urandom_range(0, 5) == 0) begin
                v.we = 0; v.sel = 0; v.wreg = 0; v.pc = 0;
                v.alu = 0; v.dout = 0; v.pc8 = 0; v.cp0 = 0;
            end
            v.exp_wd = wd_of(v);
            cycle(v);
        end

        // Counter wrap via backdoor preload
        force dut.cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.cnt_q;
        m_cnt = 32'hFFFF_FFFF;
        chk("cnt_preload", retired_cnt, 32'hFFFF_FFFF);
        cycle(mk(0, 0, 0, 0, 32'h3100, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("cnt_wrap", retired_cnt, 32'h0);

        // Reset priority over a simultaneous write
        cycle(mk(0, 1, 0, 3, 32'h3104, 32'h77, 0, 0, 0, 3, 0, 32'h77, 0, 0));
        cycle(mk(1, 1, 0, 3, 32'h3108, 32'd5, 0, 0, 0, 3, 3, 32'd5, 0, 0));
        chk("rst_prio_valid", 32'(trace_valid), 32'd0);
        chk("rst_prio_cnt", retired_cnt, 32'd0);
        chk("rst_prio_pc", trace_pc, 32'd0);
        cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 3, 0, 1, 32'd0));

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
